// File: rtl/pipe_skid_reg_pkg.sv
// Shared types and default constants for the pipe_skid_reg slice.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam int DEF_DW             = 32;
    localparam int DEF_CW             = 8;
    localparam bit DEF_CLEAR_ON_FLUSH = 1'b1;
    localparam int INC_W              = 2;

endpackage

// File: rtl/pipe_skid_reg_if.sv
// Valid/ready handshake bundle for both sides of the skid stage.
interface pipe_skid_reg_if
    import pipe_pkg::*;
#(
    parameter int DW = DEF_DW
) ();

    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready;

    // master: the environment around the stage; slave: the stage itself
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

endinterface

// File: rtl/pipe_skid_reg_sat_counter.sv
// Saturating up-counter: adds 0..3 per cycle and sticks at all-ones.
module sat_counter
    import pipe_pkg::*;
#(
    parameter int CW = DEF_CW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [INC_W-1:0] inc,
    output logic [CW-1:0]    count
);

    logic [CW+INC_W-1:0] sum;

    always_comb begin
        sum = {{INC_W{1'b0}}, count} + {{CW{1'b0}}, inc};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (sum[CW+INC_W-1:CW] != '0) begin
            count <= '1;
        end else begin
            count <= sum[CW-1:0];
        end
    end

endmodule

// File: rtl/pipe_skid_reg.sv
// Two-entry pipeline register (main + skid) with registered in_ready/out_valid,
// synchronous flush and a saturating count of entries killed by flush.
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int          DW             = DEF_DW,
    parameter logic [DW-1:0] BUBBLE       = '0,
    parameter bit          CLEAR_ON_FLUSH = DEF_CLEAR_ON_FLUSH,
    parameter int          CW             = DEF_CW
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    pipe_skid_reg_if.slave         bus,
    output logic [CW-1:0]          drop_cnt
);

    state_t           state_q, state_d;
    logic [DW-1:0]    main_q, main_d;
    logic [DW-1:0]    skid_q, skid_d;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             in_fire;
    logic             out_fire;
    logic [INC_W-1:0] held;
    logic [INC_W-1:0] drop_inc;

    assign in_fire       = bus.in_valid & in_ready_q;
    assign out_fire      = out_valid_q & bus.out_ready;
    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = main_q;

    always_comb begin
        // NOTE: defaults first so every path assigns every signal -- no latches.
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
            if (CLEAR_ON_FLUSH) begin
                main_d = BUBBLE;
                skid_d = BUBBLE;
            end
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d = BUSY;
                        main_d  = bus.in_data;
                    end
                end
                BUSY: begin
                    if (in_fire && out_fire) begin
                        main_d = bus.in_data;
                    end else if (in_fire) begin
                        state_d = FULL;
                        skid_d  = bus.in_data;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        state_d = BUSY;
                        main_d  = skid_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // Entries lost on flush: those held, minus one delivered, plus one arriving.
    always_comb begin
        held     = (state_q == FULL) ? 2'd2 : (state_q == BUSY) ? 2'd1 : 2'd0;
        drop_inc = '0;
        if (flush) begin
            drop_inc = held + {1'b0, in_fire} - {1'b0, out_fire};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: data registers are reset too, so out_data is BUBBLE, never X, after reset.
        if (!rst_n) begin
            state_q     <= EMPTY;
            main_q      <= BUBBLE;
            skid_q      <= BUBBLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            in_ready_q  <= (state_d != FULL);
            out_valid_q <= (state_d != EMPTY);
        end
    end

    sat_counter #(.CW(CW)) u_drop_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (drop_inc),
        .count (drop_cnt)
    );

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Scoreboard bench for pipe_skid_reg: a queue models the two-entry stage.
module tb_pipe_skid_reg;
    import pipe_pkg::*;

    localparam int          DW     = 32;
    localparam int          CW     = 2;
    localparam logic [DW-1:0] BUBBLE = 32'hDEAD_BEEF;

    logic          clk;
    logic          rst_n;
    logic          flush;
    logic [CW-1:0] drop_cnt;

    pipe_skid_reg_if #(.DW(DW)) bus ();

    pipe_skid_reg #(
        .DW             (DW),
        .BUBBLE         (BUBBLE),
        .CLEAR_ON_FLUSH (1'b1),
        .CW             (CW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .bus      (bus),
        .drop_cnt (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] exp_main;
    int            exp_drop;
    int            deliv_cnt;
    int            vec_cnt;
    int            err_cnt;

    // Checks the stage against the model, applies one clock edge, updates the model.
    task automatic tick();
        bit            in_fire;
        bit            out_fire;
        int            n;
        logic [DW-1:0] w;
        vec_cnt++;
        if (bus.in_ready !== (exp_q.size() < 2)) begin
            err_cnt++;
            $display("FAIL in_ready: got %b, want %b", bus.in_ready, exp_q.size() < 2);
        end
        vec_cnt++;
        if (bus.out_valid !== (exp_q.size() > 0)) begin
            err_cnt++;
            $display("FAIL out_valid: got %b, want %b", bus.out_valid, exp_q.size() > 0);
        end
        vec_cnt++;
        if (bus.out_data !== exp_main) begin
            err_cnt++;
            $display("FAIL out_data: got %h, want %h", bus.out_data, exp_main);
        end
        vec_cnt++;
        if (int'(drop_cnt) !== exp_drop) begin
            err_cnt++;
            $display("FAIL drop_cnt: got %0d, want %0d", drop_cnt, exp_drop);
        end
        in_fire  = bus.in_valid && bus.in_ready;
        out_fire = bus.out_valid && bus.out_ready;
        if (out_fire) begin
            vec_cnt++;
            if (exp_q.size() == 0) begin
                err_cnt++;
                $display("FAIL sb_pop: got %h, want no output", bus.out_data);
            end else begin
                w = exp_q.pop_front();
                deliv_cnt++;
                if (bus.out_data !== w) begin
                    err_cnt++;
                    $display("FAIL sb_data: got %h, want %h", bus.out_data, w);
                end
            end
        end
        if (flush) begin
            n        = exp_q.size() + (in_fire ? 1 : 0);
            exp_drop = (exp_drop + n > 3) ? 3 : exp_drop + n;
            exp_q.delete();
            exp_main = BUBBLE;
        end else begin
            if (in_fire) exp_q.push_back(bus.in_data);
            if (exp_q.size() > 0) exp_main = exp_q[0];
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        rst_n        = 1'b0;
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.out_ready = 1'b0;
        #1;
        exp_q.delete();
        exp_main = BUBBLE;
        exp_drop = 0;
        vec_cnt++;
        if (bus.in_ready !== 1'b1) begin
            err_cnt++;
            $display("FAIL rst_in_ready: got %b, want 1", bus.in_ready);
        end
        vec_cnt++;
        if (bus.out_valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL rst_out_valid: got %b, want 0", bus.out_valid);
        end
        vec_cnt++;
        if (bus.out_data !== BUBBLE) begin
            err_cnt++;
            $display("FAIL rst_out_data: got %h, want %h", bus.out_data, BUBBLE);
        end
        vec_cnt++;
        if (drop_cnt !== '0) begin
            err_cnt++;
            $display("FAIL rst_drop_cnt: got %0d, want 0", drop_cnt);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_latency();
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'h1234_5678;
        tick();
        bus.in_valid = 1'b0;
        vec_cnt++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h1234_5678 || bus.in_ready !== 1'b1) begin
            err_cnt++;
            $display("FAIL latency: got v=%b d=%h r=%b, want v=1 d=12345678 r=1",
                     bus.out_valid, bus.out_data, bus.in_ready);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int d0;
        d0 = deliv_cnt;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.in_data = 32'h0100_0000 + i;
            tick();
        end
        bus.in_valid = 1'b0;
        vec_cnt++;
        if (deliv_cnt - d0 !== 7) begin
            err_cnt++;
            $display("FAIL back_to_back: got %0d delivered, want 7", deliv_cnt - d0);
        end
        tick();
    endtask

    task automatic fill_two(input logic [DW-1:0] a, input logic [DW-1:0] b);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = a;
        tick();
        bus.in_data = b;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic test_fill_drain();
        fill_two(32'hA, 32'hB);
        vec_cnt++;
        if (bus.in_ready !== 1'b0 || bus.out_data !== 32'hA) begin
            err_cnt++;
            $display("FAIL full: got r=%b d=%h, want r=0 d=a", bus.in_ready, bus.out_data);
        end
        bus.out_ready = 1'b1;
        tick();
        vec_cnt++;
        if (bus.in_ready !== 1'b1 || bus.out_data !== 32'hB) begin
            err_cnt++;
            $display("FAIL drain: got r=%b d=%h, want r=1 d=b", bus.in_ready, bus.out_data);
        end
        tick();
        vec_cnt++;
        if (bus.out_valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL drained: got v=%b, want 0", bus.out_valid);
        end
    endtask

    task automatic test_flush_full();
        fill_two(32'hA, 32'hB);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        vec_cnt++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== BUBBLE || drop_cnt !== 2'd2) begin
            err_cnt++;
            $display("FAIL flush_full: got v=%b d=%h c=%0d, want v=0 d=%h c=2",
                     bus.out_valid, bus.out_data, drop_cnt, BUBBLE);
        end
    endtask

    task automatic test_saturate();
        fill_two(32'hC, 32'hD);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        vec_cnt++;
        if (drop_cnt !== 2'd3) begin
            err_cnt++;
            $display("FAIL sat_reach: got %0d, want 3", drop_cnt);
        end
        fill_two(32'hE, 32'hF);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        vec_cnt++;
        if (drop_cnt !== 2'd3) begin
            err_cnt++;
            $display("FAIL sat_hold: got %0d, want 3", drop_cnt);
        end
    endtask

    task automatic test_reset_mid();
        fill_two(32'h11, 32'h22);
        test_reset();
    endtask

    task automatic test_flush_fire();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'h33;
        tick();
        bus.in_data   = 32'h44;
        bus.out_ready = 1'b1;
        flush         = 1'b1;
        tick();
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        vec_cnt++;
        if (drop_cnt !== 2'd1 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            err_cnt++;
            $display("FAIL flush_fire: got c=%0d v=%b r=%b, want c=1 v=0 r=1",
                     drop_cnt, bus.out_valid, bus.in_ready);
        end
        tick();
    endtask

    task automatic test_stream();
        int            sent;
        int            cycles;
        int            d0;
        bit            fire;
        logic [DW-1:0] word;
        sent         = 0;
        cycles       = 0;
        d0           = deliv_cnt;
        word         = $urandom;
        bus.in_valid = 1'b0;
        while ((sent < 100 || exp_q.size() != 0) && cycles < 3000) begin
            if (sent < 100 && !bus.in_valid) bus.in_valid = ($urandom_range(0, 3) != 0);
            bus.in_data   = word;
            bus.out_ready = ($urandom_range(0, 2) != 0);
            fire = bus.in_valid && bus.in_ready;
            tick();
            cycles++;
            if (fire) begin
                sent++;
                word         = $urandom;
                bus.in_valid = (sent < 100) && ($urandom_range(0, 1) != 0);
            end
        end
        bus.in_valid = 1'b0;
        vec_cnt++;
        if (cycles >= 3000 || deliv_cnt - d0 !== 100) begin
            err_cnt++;
            $display("FAIL stream: got %0d delivered in %0d cycles, want 100", deliv_cnt - d0, cycles);
        end
    endtask

    initial begin
        rst_n         = 1'b1;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        vec_cnt       = 0;
        err_cnt       = 0;
        deliv_cnt     = 0;
        exp_main      = BUBBLE;
        exp_drop      = 0;

        test_reset();
        test_latency();
        test_back_to_back();
        test_fill_drain();
        test_flush_full();
        test_saturate();
        test_reset_mid();
        test_flush_fire();
        test_stream();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 Parameter DW, default 32, payload width in bits (1..512).
REQ-002 Parameter BUBBLE, default 0 (DW bits), value loaded into data registers on reset and on a clearing flush.
REQ-003 Parameter CLEAR_ON_FLUSH, default 1; 1 = flush overwrites data registers with BUBBLE, 0 = flush only invalidates.
REQ-004 Parameter CW, default 8, width of the flush-drop counter.
REQ-005 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-006 Port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 Port flush  input  1  synchronous kill of all held entries and of any same-cycle input.
REQ-008 Port in_valid  input  1  upstream entry offered.
REQ-009 Port in_data  input  DW  upstream payload.
REQ-010 Port in_ready  output  1  stage can accept; driven directly from a register.
REQ-011 Port out_valid  output  1  head entry valid.
REQ-012 Port out_data  output  DW  head payload; driven directly from a register.
REQ-013 Port out_ready  input  1  downstream accepts head.
REQ-014 Port drop_cnt  output  CW  saturating count of valid entries discarded by flush.

Function
REQ-015 Input fire = in_valid & in_ready; output fire = out_valid & out_ready.
REQ-016 Storage: main register (head) plus one skid register; state machine EMPTY / BUSY / FULL.
REQ-017 EMPTY: no fire in -> EMPTY; fire in -> BUSY, main <= in_data.
REQ-018 BUSY: in fire only -> FULL, skid <= in_data; out fire only -> EMPTY; both -> BUSY, main <= in_data; neither -> BUSY.
REQ-019 FULL: out fire -> BUSY, main <= skid; otherwise hold; in_ready = 0 so no input fire occurs.
REQ-020 in_ready = 1 in EMPTY and BUSY, 0 in FULL, registered with the state.
REQ-021 out_valid = 1 in BUSY and FULL; out_data = main register.
REQ-022 Latency: data accepted into EMPTY appears at out_data with out_valid = 1 in the next cycle.
REQ-023 Throughput: one entry per cycle sustained while out_ready = 1.
REQ-024 Order preserved; no entry duplicated or lost except by flush.
REQ-025 out_data stable while out_valid = 1 and out_ready = 0.
REQ-026 Flush has priority over all handshakes: next state EMPTY, same-cycle input fire discarded, same-cycle output fire counts as delivered.
REQ-027 With flush and CLEAR_ON_FLUSH = 1, main and skid <= BUBBLE; with 0, data registers hold.
REQ-028 drop_cnt += (entries valid at flush) - (1 if output fire that cycle) + (1 if input fire that cycle), saturating at 2^CW-1, never wrapping.
REQ-029 in_valid without in_ready: upstream holds; stage samples nothing.

Reset
REQ-030 rst_n = 0 asynchronously forces state EMPTY, main = skid = BUBBLE, in_ready = 1, out_valid = 0, drop_cnt = 0.
REQ-031 Reset mid-transfer discards all entries without counting them; first fire allowed in the first clock after rst_n rises.

Structure
REQ-032 Package pipe_pkg holds the state enumeration (EMPTY, BUSY, FULL) and default parameter constants.
REQ-033 One sub-module sat_counter (width CW, increment 0..3, saturating) implements drop_cnt; the rest is flat.

Verification
REQ-034 Reset then in_data = 0x1234_5678 with in_valid = 1 and out_ready = 1 -> out_valid = 1, out_data = 0x1234_5678 next cycle; in_ready stays 1.
REQ-035 out_ready = 0, feed 0xA, 0xB -> state FULL, in_ready = 0 in cycle 3; raise out_ready -> outputs 0xA then 0xB in order, in_ready back to 1.
REQ-036 FULL (0xA, 0xB), flush with out_ready = 0, CLEAR_ON_FLUSH = 1 -> out_valid = 0, out_data = BUBBLE, drop_cnt = 2.
REQ-037 CW = 2, repeated FULL flushes -> drop_cnt reaches 3 and holds at 3.
REQ-038 Stream 100 random words, random out_ready -> scoreboard matches every word in order, out_data never changes while stalled.
REQ-039 rst_n pulled low mid-cycle while FULL -> outputs reach reset values before the next clock edge, drop_cnt = 0.
